// File: rtl/regfile_pkg.sv
// Shared widths, constants and types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Writes to this index are architecturally discarded.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Round-robin pointer: which source received the most recent grant.
    typedef enum logic {
        LAST_A,
        LAST_B
    } rr_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot. Load wins over clear, so a slot can be
// drained and refilled at the same edge.
module wb_slot #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_reg,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [ADDR_W-1:0] r_reg;
    logic [DATA_W-1:0] r_data;

    // Slot contents: capture on load, drop the full flag on clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_full <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_reg  <= i_reg;
            r_data <= i_data;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_reg  = r_reg;
    assign o_data = r_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between an ALU source (A) and a
// load source (B). Each source has a one-entry slot; a round-robin arbiter,
// overridden by slot age when both slots target the same register, drains
// the slots. Pending slot data is forwarded to the two read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    output logic              Fwd1Valid,
    output logic [DATA_W-1:0] Fwd1Data,
    output logic              Fwd2Valid,
    output logic [DATA_W-1:0] Fwd2Data
);

    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

    logic              w_a_full, w_b_full;
    logic [ADDR_W-1:0] w_a_reg, w_b_reg;
    logic [DATA_W-1:0] w_a_data, w_b_data;
    logic              w_grant_a, w_grant_b;
    logic              w_load_a, w_load_b;
    logic              w_a_keep, w_b_keep;
    logic              w_age_d;
    rr_e               w_rr_d;
    logic              w_m1a, w_m1b, w_m2a, w_m2b;

    // r_age = 1 means slot A holds the older entry.
    logic r_age;
    rr_e  r_rr;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_load    (w_load_a),
        .i_clear   (w_grant_a),
        .i_reg     (a_reg),
        .i_data    (a_data),
        .o_full    (w_a_full),
        .o_reg     (w_a_reg),
        .o_data    (w_a_data)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_load    (w_load_b),
        .i_clear   (w_grant_b),
        .i_reg     (b_reg),
        .i_data    (b_data),
        .o_full    (w_b_full),
        .o_reg     (w_b_reg),
        .o_data    (w_b_data)
    );

    // Grant: same destination keeps program order via age, otherwise round-robin.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_a_full && w_b_full) begin
            if (w_a_reg == w_b_reg) begin
                w_grant_a = r_age;
                w_grant_b = !r_age;
            end else if (r_rr == LAST_A) begin
                w_grant_b = 1'b1;
            end else begin
                w_grant_a = 1'b1;
            end
        end else begin
            w_grant_a = w_a_full;
            w_grant_b = w_b_full;
        end
    end

    // Ready depends only on slot state and grant, never on the valids.
    assign a_ready  = reset_n & (!w_a_full | w_grant_a);
    assign b_ready  = reset_n & (!w_b_full | w_grant_b);
    // Register-0 writes complete the handshake but never occupy a slot.
    assign w_load_a = a_valid & a_ready & (a_reg != ZeroIdx);
    assign w_load_b = b_valid & b_ready & (b_reg != ZeroIdx);
    assign w_a_keep = w_a_full & !w_grant_a;
    assign w_b_keep = w_b_full & !w_grant_b;

    // Age and round-robin next state: a fresh load is younger than a surviving peer.
    always_comb begin
        w_age_d = r_age;
        if (w_load_a && w_load_b) begin
            w_age_d = 1'b1;
        end else if (w_load_a) begin
            w_age_d = !w_b_keep;
        end else if (w_load_b) begin
            w_age_d = w_a_keep;
        end
        w_rr_d = r_rr;
        if (w_grant_a) begin
            w_rr_d = LAST_A;
        end else if (w_grant_b) begin
            w_rr_d = LAST_B;
        end
    end

    // Arbiter state; reset leaves B as last grant so A wins first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_age <= 1'b1;
            r_rr  <= LAST_B;
        end else begin
            r_age <= w_age_d;
            r_rr  <= w_rr_d;
        end
    end

    // Write port driven from the granted slot, zero when idle.
    always_comb begin
        RegWrite  = w_grant_a | w_grant_b;
        WriteReg  = '0;
        WriteData = '0;
        if (w_grant_a) begin
            WriteReg  = w_a_reg;
            WriteData = w_a_data;
        end else if (w_grant_b) begin
            WriteReg  = w_b_reg;
            WriteData = w_b_data;
        end
    end

    // Forwarding of pending data; on a double match the younger slot is newest.
    always_comb begin
        w_m1a     = w_a_full && (Read1 == w_a_reg) && (Read1 != ZeroIdx);
        w_m1b     = w_b_full && (Read1 == w_b_reg) && (Read1 != ZeroIdx);
        w_m2a     = w_a_full && (Read2 == w_a_reg) && (Read2 != ZeroIdx);
        w_m2b     = w_b_full && (Read2 == w_b_reg) && (Read2 != ZeroIdx);
        Fwd1Valid = w_m1a | w_m1b;
        Fwd2Valid = w_m2a | w_m2b;
        Fwd1Data  = '0;
        Fwd2Data  = '0;
        if (w_m1a && w_m1b) begin
            Fwd1Data = r_age ? w_b_data : w_a_data;
        end else if (w_m1a) begin
            Fwd1Data = w_a_data;
        end else if (w_m1b) begin
            Fwd1Data = w_b_data;
        end
        if (w_m2a && w_m2b) begin
            Fwd2Data = r_age ? w_b_data : w_a_data;
        end else if (w_m2a) begin
            Fwd2Data = w_a_data;
        end else if (w_m2b) begin
            Fwd2Data = w_b_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file.
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  Read1, Read2;
    logic        Fwd1Valid, Fwd2Valid;
    logic [31:0] Fwd1Data, Fwd2Data;

    logic [31:0] regs [32];
    int          n_tests;
    int          n_fail;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Read1     (Read1),
        .Read2     (Read2),
        .Fwd1Valid (Fwd1Valid),
        .Fwd1Data  (Fwd1Data),
        .Fwd2Valid (Fwd2Valid),
        .Fwd2Data  (Fwd2Data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: index 0 is hardwired to zero.
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
    end
    always @(posedge clock) begin
        if (RegWrite && WriteReg != 5'd0) regs[WriteReg] <= WriteData;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        Read1 = '0; Read2 = '0;

        // Reset state
        #3;
        check_eq("rst_regwrite", 32'(RegWrite), 32'd0);
        check_eq("rst_writereg", 32'(WriteReg), 32'd0);
        check_eq("rst_writedata", WriteData, 32'd0);
        check_eq("rst_a_ready", 32'(a_ready), 32'd0);
        check_eq("rst_b_ready", 32'(b_ready), 32'd0);
        check_eq("rst_fwd1", 32'(Fwd1Valid), 32'd0);
        check_eq("rst_fwd2data", Fwd2Data, 32'd0);
        #1 reset_n = 1'b1;
        #1;
        check_eq("idle_a_ready", 32'(a_ready), 32'd1);

        // Single write: accept at edge k, write at edge k+1
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h1234; Read1 = 5'd3;
        step();
        a_valid = 1'b0;
        #1;
        check_eq("single_regwrite", 32'(RegWrite), 32'd1);
        check_eq("single_writereg", 32'(WriteReg), 32'd3);
        check_eq("single_writedata", WriteData, 32'h1234);
        check_eq("single_fwd1valid", 32'(Fwd1Valid), 32'd1);
        check_eq("single_fwd1data", Fwd1Data, 32'h1234);
        step();
        check_eq("single_idle", 32'(RegWrite), 32'd0);
        check_eq("single_rf3", regs[3], 32'h1234);
        check_eq("single_fwd1gone", 32'(Fwd1Valid), 32'd0);

        // Contention on different registers: A,B,A,B from reset
        pulse_reset();
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'hAAAA;
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'hBBBB;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr_writereg%0d", i), 32'(WriteReg), (i % 2 == 0) ? 32'd4 : 32'd5);
            check_eq($sformatf("rr_writedata%0d", i), WriteData,
                     (i % 2 == 0) ? 32'hAAAA : 32'hBBBB);
            check_eq($sformatf("rr_a_ready%0d", i), 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("rr_b_ready%0d", i), 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        check_eq("rr_drain_b", 32'(WriteReg), 32'd5);
        step();
        check_eq("rr_drained", 32'(RegWrite), 32'd0);
        check_eq("rr_rf4", regs[4], 32'hAAAA);
        check_eq("rr_rf5", regs[5], 32'hBBBB);

        // Same-register order: A(7,1) then B(7,2) one edge later
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h1;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h2;
        #1;
        check_eq("order_first", WriteData, 32'h1);
        check_eq("order_b_ready", 32'(b_ready), 32'd1);
        step();
        b_valid = 1'b0;
        check_eq("order_second", WriteData, 32'h2);
        check_eq("order_second_reg", 32'(WriteReg), 32'd7);
        step();
        check_eq("order_rf7", regs[7], 32'h2);

        // Age beats rr: both slots hold reg 9, A older, last grant was A
        a_valid = 1'b1; a_reg = 5'd12; a_data = 32'h55;
        step();
        a_reg = 5'd9; a_data = 32'hDEAD;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hBEEF;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        Read1 = 5'd9; Read2 = 5'd8;
        #1;
        check_eq("age_rf12", regs[12], 32'h55);
        check_eq("age_writedata", WriteData, 32'hDEAD);
        check_eq("fwd1_valid", 32'(Fwd1Valid), 32'd1);
        check_eq("fwd1_data", Fwd1Data, 32'hBEEF);
        check_eq("fwd2_valid", 32'(Fwd2Valid), 32'd0);
        check_eq("fwd2_data", Fwd2Data, 32'd0);
        step();
        check_eq("age_second", WriteData, 32'hBEEF);
        check_eq("age_fwd1_b", Fwd1Data, 32'hBEEF);
        step();
        check_eq("age_rf9", regs[9], 32'hBEEF);
        check_eq("age_idle", 32'(RegWrite), 32'd0);

        // Register 0 is accepted and discarded
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF; Read1 = 5'd0;
        #1;
        check_eq("zero_b_ready", 32'(b_ready), 32'd1);
        step();
        b_valid = 1'b0;
        check_eq("zero_regwrite", 32'(RegWrite), 32'd0);
        check_eq("zero_fwd1", 32'(Fwd1Valid), 32'd0);
        check_eq("zero_b_ready_after", 32'(b_ready), 32'd1);
        step();
        check_eq("zero_regwrite2", 32'(RegWrite), 32'd0);
        check_eq("zero_rf0", regs[Read1], 32'd0);

        // Reset mid-operation discards both pending slots
        a_valid = 1'b1; a_reg = 5'd20; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd21; b_data = 32'h22;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("mid_regwrite_pre", 32'(RegWrite), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_regwrite_rst", 32'(RegWrite), 32'd0);
        check_eq("mid_a_ready_rst", 32'(a_ready), 32'd0);
        check_eq("mid_b_ready_rst", 32'(b_ready), 32'd0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("mid_nowrite%0d", i), 32'(RegWrite), 32'd0);
        end
        check_eq("mid_rf20", regs[20], 32'd0);
        check_eq("mid_rf21", regs[21], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WriteReg/WriteData/RegWrite) between two writeback sources: A (ALU result) and B (memory load).
- Each source has a valid/ready handshake and a one-entry holding slot.
- A round-robin arbiter drains the slots into `registerfile`, preserving program order per destination register.
- Provides forwarding of pending (buffered, not yet written) data to the register-file read ports.

Parameters:
- DATA_W, 32: data width, matches register-file width.
- ADDR_W, 5: register index width (32 registers).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  source A has a write.
- a_ready  out  1  source A write accepted this cycle when a_valid=1.
- a_reg  in  ADDR_W  source A destination register.
- a_data  in  DATA_W  source A data.
- b_valid  in  1  source B has a write.
- b_ready  out  1  source B write accepted this cycle when b_valid=1.
- b_reg  in  ADDR_W  source B destination register.
- b_data  in  DATA_W  source B data.
- RegWrite  out  1  write enable to registerfile.
- WriteReg  out  ADDR_W  write index to registerfile.
- WriteData  out  DATA_W  write data to registerfile.
- Read1  in  ADDR_W  register-file read index 1 (snooped).
- Read2  in  ADDR_W  register-file read index 2 (snooped).
- Fwd1Valid  out  1  a pending write targets Read1.
- Fwd1Data  out  DATA_W  pending data for Read1.
- Fwd2Valid  out  1  a pending write targets Read2.
- Fwd2Data  out  DATA_W  pending data for Read2.

Behaviour:
- State:
  - slotA and slotB, each holding full, reg and data.
  - age bit: 1 means slotA is older.
  - rr pointer: last grant, values LAST_A or LAST_B.
- Reset (reset_n low, asynchronous):
  - Slots empty, age=1, rr=LAST_B (so A wins first).
  - a_ready=b_ready=0 while reset_n is low.
  - RegWrite=0, WriteReg=0, WriteData=0, Fwd*Valid=0, Fwd*Data=0.
- Grant (combinational, each cycle):
  - Only slotA full: grant A. Only slotB full: grant B.
  - Both full with equal reg: grant the older slot (age), regardless of rr.
  - Both full with different reg: grant the slot not named by rr. Round-robin alternates A,B,A,B under sustained load.
- Write port:
  - RegWrite=1 when any slot is granted; WriteReg/WriteData come from the granted slot.
  - WriteReg/WriteData are 0 when RegWrite=0.
  - The granted slot clears at the same rising edge at which registerfile commits the write.
  - rr updates to the granted source at that edge.
- Handshake:
  - x_ready = reset_n & (!slotX.full | grantX).
  - A transfer occurs at the rising edge when x_valid & x_ready.
  - Accepted data is loaded into the slot at that edge.
- Latency: minimum is accept at edge k, registerfile written at edge k+1.
- Throughput: one write per cycle total. Each source sustains one transfer per cycle when uncontended.
- Register 0:
  - A transfer with reg==0 is accepted (ready per the rule above) and discarded.
  - The slot stays empty and RegWrite is never asserted for index 0.
- Age:
  - A load into an empty slot while the other slot stays full (not granted) makes the loaded slot younger.
  - Simultaneous loads into both slots: A is older (age=1).
  - A load into a slot whose peer is being granted this cycle: the loaded slot becomes older once the peer clears, i.e. the age bit is set to point at the surviving slot.
- Forwarding (combinational) for each read port n:
  - FwdnValid=1 when Readn!=0 and Readn matches a full slot's reg.
  - If both slots match, forward the younger slot's data.
  - A slot being written in the current cycle still forwards; registerfile only reflects the write after the edge.
  - FwdnData=0 when FwdnValid=0.
- Reset mid-operation: pending slot contents are lost, with no write issued. Sources must re-present writes after reset.
- No combinational path from RegWrite back to a source's valid input.

Decomposition:
- Package regfile_pkg:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant (5'd0).
  - rr_e enum {LAST_A, LAST_B}.
- Sub-module wb_slot, instantiated twice:
  - One-entry holding register with load/clear, full flag, reg and data.
  - Async active-low reset.

Test Plan:
- Reset then single write: a_valid=1, a_reg=3, a_data=32'h1234 for one cycle. Expect RegWrite=1, WriteReg=3, WriteData=32'h1234 in the next cycle. Registerfile Data1 reads 32'h1234 with Read1=3 afterwards.
- Contention, different regs: A (reg 4, 32'hAAAA) and B (reg 5, 32'hBBBB) are both valid continuously. Writes must alternate A,B,A,B, with first grant to A after reset. a_ready/b_ready must each toggle so that both sources progress.
- Same-reg ordering: A (reg 7, 32'h1) accepted at edge k, B (reg 7, 32'h2) at edge k+1 while slotA is still full. The write sequence must be 1 then 2 even if rr favours B. Read of reg 7 afterwards gives 32'h2.
- Forwarding: slotA holds reg 9/32'hDEAD and slotB holds reg 9/32'hBEEF (younger), with Read1=9 and Read2=8. Expect Fwd1Valid=1, Fwd1Data=32'hBEEF, Fwd2Valid=0, Fwd2Data=0.
- Zero register: b_valid=1, b_reg=0, b_data=32'hFFFFFFFF. Expect b_ready=1 and RegWrite stays 0. Read1=0 gives Fwd1Valid=0 and Data1=0.
- Reset mid-operation: both slots full, reset_n pulsed low asynchronously between edges. RegWrite drops to 0 immediately, ready is low while reset is asserted, and no write is issued after release.
